// File: rtl/d_to_sr_ff_bank_pkg.sv
// Shared types for the D-register-based SR flip-flop bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Provides the per-cell state encoding, the RESOLVE selector constants and
// a helper that maps a RESOLVE value to the state a cell settles into.
package d_to_sr_ff_bank_pkg;

    typedef enum logic [1:0] {
        ST_Q0     = 2'b00,
        ST_Q1     = 2'b01,
        ST_FORBID = 2'b10
    } sr_state_t;

    localparam int RES_Q0 = 0;
    localparam int RES_Q1 = 1;

    // State a cell falls into when S=R=0 is sampled while it sits in FORBID.
    function automatic sr_state_t resolve_state(input int res);
        return (res == RES_Q1) ? ST_Q1 : ST_Q0;
    endfunction

endpackage

// File: rtl/d_to_sr_ff_bank_if.sv
// Bus bundle between the SR bank and whatever drives it.
// Latency: n/a (wiring only).
// Backpressure: none; every cycle with en=1 is consumed by the bank.
//
// master: drives en/s/r/err_clr, observes q/qb/illegal/err_sticky/illegal_cnt.
// slave : the bank itself.
interface d_to_sr_ff_bank_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] illegal;
    logic             err_sticky;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output en, s, r, err_clr,
        input  q, qb, illegal, err_sticky, illegal_cnt
    );

    modport slave (
        input  en, s, r, err_clr,
        output q, qb, illegal, err_sticky, illegal_cnt
    );
endinterface

// File: rtl/d_to_sr_ff_bank_sr_cell.sv
// One SR flip-flop cell: 3-state FSM (Q0/Q1/FORBID) with registered q/qb and illegal pulse.
// Latency: q/qb/illegal update one clk after s/r are sampled with en=1.
// Backpressure: none; en=0 freezes the state and suppresses the illegal pulse.
//
// Ports: clk, reset (async active-low), en, s, r -> q, qb, illegal.
module d_to_sr_ff_bank_sr_cell
    import d_to_sr_ff_bank_pkg::*;
#(
    parameter int RESOLVE = RES_Q0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qb,
    output logic illegal
);

    sr_state_t state;
    sr_state_t state_nxt;

    always_comb begin
        state_nxt = state;
        case ({s, r})
            2'b10:   state_nxt = ST_Q1;
            2'b01:   state_nxt = ST_Q0;
            2'b11:   state_nxt = ST_FORBID;
            default: begin
                if (state == ST_FORBID) begin
                    state_nxt = resolve_state(RESOLVE);
                end
            end
        endcase
    end

    // q/qb are registered from the next state so FORBID shows q=qb=0 in
    // the same cycle the state register holds FORBID.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_Q0;
            q       <= 1'b0;
            qb      <= 1'b1;
            illegal <= 1'b0;
        end else if (en) begin
            state   <= state_nxt;
            q       <= (state_nxt == ST_Q1);
            qb      <= (state_nxt == ST_Q0);
            illegal <= s & r;
        end else begin
            illegal <= 1'b0;
        end
    end

endmodule

// File: rtl/d_to_sr_ff_bank.sv
// Bank of WIDTH independent SR flip-flops with illegal-use reporting (sticky flag, event counter).
// Latency: all outputs registered, one clk after the sampled inputs.
// Backpressure: none; en=0 holds every cell and stops illegal reporting.
//
// Ports: clk, reset (async active-low), bus (d_to_sr_ff_bank_if.slave).
// Build option: define D_TO_SR_ILLEGAL_CNT_EN to implement illegal_cnt;
// otherwise illegal_cnt is tied to zero and the port stays for a stable interface.
module d_to_sr_ff_bank
    import d_to_sr_ff_bank_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int RESOLVE = RES_Q0,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    d_to_sr_ff_bank_if.slave     bus
);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qb_w;
    logic [WIDTH-1:0] illegal_w;
    logic             any_illegal;
    logic             err_sticky_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        d_to_sr_ff_bank_sr_cell #(
            .RESOLVE (RESOLVE)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .en      (bus.en),
            .s       (bus.s[i]),
            .r       (bus.r[i]),
            .q       (q_w[i]),
            .qb      (qb_w[i]),
            .illegal (illegal_w[i])
        );
    end

    // OR-reduce of the sampled per-cell illegal condition (the same term
    // each cell registers), so the flag and counter line up with illegal.
    assign any_illegal = bus.en & (|(bus.s & bus.r));

    // A new illegal sample beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_sticky_r <= 1'b0;
        end else if (any_illegal) begin
            err_sticky_r <= 1'b1;
        end else if (bus.err_clr) begin
            err_sticky_r <= 1'b0;
        end
    end

`ifdef D_TO_SR_ILLEGAL_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] illegal_cnt_r;

    // Saturating; a clear coinciding with an illegal cycle leaves 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_cnt_r <= '0;
        end else if (bus.err_clr) begin
            illegal_cnt_r <= {{(CNT_W-1){1'b0}}, any_illegal};
        end else if (any_illegal && (illegal_cnt_r != CNT_MAX)) begin
            illegal_cnt_r <= illegal_cnt_r + 1'b1;
        end
    end

    assign bus.illegal_cnt = illegal_cnt_r;
`else
    assign bus.illegal_cnt = '0;
`endif

    assign bus.q          = q_w;
    assign bus.qb         = qb_w;
    assign bus.illegal    = illegal_w;
    assign bus.err_sticky = err_sticky_r;

endmodule

// File: tb/tb_d_to_sr_ff_bank.sv
// Self-checking bench for d_to_sr_ff_bank: three instances (RESOLVE=0, RESOLVE=1, CNT_W=3)
// share one stimulus stream; a reference model pushes expected outputs to a queue
// and each test task pops and compares them after the clock edge.
module tb_d_to_sr_ff_bank;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] qb;
        logic [3:0] ill;
        logic       st;
        logic [7:0] cnt;
    } obs_t;

    typedef obs_t [2:0] all_t;

    logic clk;
    logic reset;

    d_to_sr_ff_bank_if #(.WIDTH(4), .CNT_W(8)) i0 ();
    d_to_sr_ff_bank_if #(.WIDTH(4), .CNT_W(8)) i1 ();
    d_to_sr_ff_bank_if #(.WIDTH(4), .CNT_W(3)) i2 ();

    d_to_sr_ff_bank #(.WIDTH(4), .RESOLVE(0), .CNT_W(8)) u0 (.clk(clk), .reset(reset), .bus(i0.slave));
    d_to_sr_ff_bank #(.WIDTH(4), .RESOLVE(1), .CNT_W(8)) u1 (.clk(clk), .reset(reset), .bus(i1.slave));
    d_to_sr_ff_bank #(.WIDTH(4), .RESOLVE(0), .CNT_W(3)) u2 (.clk(clk), .reset(reset), .bus(i2.slave));

    int   checks = 0;
    int   fails  = 0;
    all_t sb[$];
    all_t got;
    all_t exp_v;

    // Reference model state per instance
    int mst[3][4];
    bit msticky[3];
    int mcnt[3];
    int res_k[3] = '{0, 1, 0};
    int cw_k[3]  = '{8, 8, 3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic all_t observe();
        all_t o;
        o[0] = {i0.q, i0.qb, i0.illegal, i0.err_sticky, i0.illegal_cnt};
        o[1] = {i1.q, i1.qb, i1.illegal, i1.err_sticky, i1.illegal_cnt};
        o[2] = {i2.q, i2.qb, i2.illegal, i2.err_sticky, 5'd0, i2.illegal_cnt};
        return o;
    endfunction

    function automatic all_t model_outputs(input logic [3:0] ill);
        all_t x;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                x[k].q[i]  = (mst[k][i] == 1);
                x[k].qb[i] = (mst[k][i] == 0);
            end
            x[k].ill = ill;
            x[k].st  = msticky[k];
`ifdef D_TO_SR_ILLEGAL_CNT_EN
            x[k].cnt = 8'(mcnt[k]);
`else
            x[k].cnt = 8'd0;
`endif
        end
        return x;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) mst[k][i] = 0;
            msticky[k] = 1'b0;
            mcnt[k]    = 0;
        end
        sb.push_back(model_outputs(4'b0000));
    endtask

    task automatic model_step(input bit e, input logic [3:0] sv, input logic [3:0] rv, input bit clr);
        logic [3:0] ill;
        bit any;
        ill = e ? (sv & rv) : 4'b0000;
        any = (ill != 4'b0000);
        for (int k = 0; k < 3; k++) begin
            if (e) begin
                for (int i = 0; i < 4; i++) begin
                    if (sv[i] && !rv[i])      mst[k][i] = 1;
                    else if (!sv[i] && rv[i]) mst[k][i] = 0;
                    else if (sv[i] && rv[i])  mst[k][i] = 2;
                    else if (mst[k][i] == 2)  mst[k][i] = res_k[k];
                end
            end
            if (any)      msticky[k] = 1'b1;
            else if (clr) msticky[k] = 1'b0;
            if (clr)                                       mcnt[k] = any ? 1 : 0;
            else if (any && mcnt[k] < (1 << cw_k[k]) - 1) mcnt[k] = mcnt[k] + 1;
        end
        sb.push_back(model_outputs(ill));
    endtask

    // Drive one sampled cycle into all instances and the model; returns at posedge+1.
    task automatic apply(input bit e, input logic [3:0] sv, input logic [3:0] rv, input bit clr);
        i0.en = e; i0.s = sv; i0.r = rv; i0.err_clr = clr;
        i1.en = e; i1.s = sv; i1.r = rv; i1.err_clr = clr;
        i2.en = e; i2.s = sv; i2.r = rv; i2.err_clr = clr;
        model_step(e, sv, rv, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            model_reset();
            @(posedge clk);
            #1;
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL reset_hold cyc%0d: got=%h exp=%h", n, got, exp_v);
            end
        end
        reset = 1'b1;
        apply(1'b1, 4'b0000, 4'b0000, 1'b0);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL reset_release: got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_set_reset();
        logic [3:0] sv[4] = '{4'b0101, 4'b1111, 4'b1111, 4'b0000};
        logic [3:0] rv[4] = '{4'b1010, 4'b0000, 4'b1111, 4'b0000};
        bit         ev[4] = '{1'b1,    1'b0,    1'b0,    1'b1};
        for (int n = 0; n < 4; n++) begin
            apply(ev[n], sv[n], rv[n], 1'b0);
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL set_reset_hold step%0d: got=%h exp=%h", n, got, exp_v);
            end
        end
    endtask

    task automatic test_forbid();
        logic [3:0] sv[3] = '{4'b0001, 4'b0001, 4'b0000};
        logic [3:0] rv[3] = '{4'b0001, 4'b0001, 4'b0000};
        for (int n = 0; n < 3; n++) begin
            apply(1'b1, sv[n], rv[n], 1'b0);
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL forbid_entry_exit step%0d: got=%h exp=%h", n, got, exp_v);
            end
        end
    endtask

    task automatic test_counter();
        apply(1'b1, 4'b0000, 4'b0000, 1'b1);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL counter_clear: got=%h exp=%h", got, exp_v);
        end
        for (int n = 0; n < 11; n++) begin
            apply(1'b1, 4'b1111, 4'b1111, 1'b0);
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL counter_sat cyc%0d: got=%h exp=%h", n, got, exp_v);
            end
        end
    endtask

    task automatic test_clear_collision();
        apply(1'b1, 4'b0001, 4'b0001, 1'b1);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL clear_collision: got=%h exp=%h", got, exp_v);
        end
        apply(1'b1, 4'b0000, 4'b0000, 1'b1);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL clear_alone: got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_reset_mid_forbid();
        apply(1'b1, 4'b1111, 4'b1111, 1'b0);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL mid_forbid_entry: got=%h exp=%h", got, exp_v);
        end
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL mid_forbid_async_reset: got=%h exp=%h", got, exp_v);
        end
        #1;
        reset = 1'b1;
        apply(1'b1, 4'b0000, 4'b0000, 1'b0);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL mid_forbid_after_release: got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            apply($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), $urandom_range(0, 7) == 0);
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL back_to_back cyc%0d: got=%h exp=%h", n, got, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        i0.en = 1'b1; i0.s = '0; i0.r = '0; i0.err_clr = 1'b0;
        i1.en = 1'b1; i1.s = '0; i1.r = '0; i1.err_clr = 1'b0;
        i2.en = 1'b1; i2.s = '0; i2.r = '0; i2.err_clr = 1'b0;
        test_reset();
        test_set_reset();
        test_forbid();
        test_counter();
        test_clear_collision();
        test_reset_mid_forbid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/d_to_sr_ff_bank.md
Name: d_to_sr_ff_bank

Overview:
- Bank of WIDTH SR flip-flops built from D-type registers. Each cell's next state is computed from the S/R inputs and the current state.
- This is the converse of the team's SR-to-D conversion cell.
- Models the NOR-latch forbidden state explicitly, so downstream logic and benches get a cycle-accurate record of illegal S=R=1 use. It also reports that use through pulses, a sticky error flag and an event counter.
- Sits beside the existing flip-flop library cells as the reference SR element for the sequential-logic exercises.

Parameters:
- WIDTH, 4, number of independent SR cells.
- RESOLVE, 0, state entered when a cell leaves FORBID with S=R=0: 0 goes to Q0, 1 goes to Q1.
- CNT_W, 8, width of the illegal-event counter (saturating).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- en  input  1  cell update enable; when 0, all cells hold.
- s  input  WIDTH  per-cell set.
- r  input  WIDTH  per-cell reset.
- err_clr  input  1  synchronous clear of err_sticky and illegal_cnt.
- q  output  WIDTH  true output.
- qb  output  WIDTH  complementary output; not guaranteed to be ~q, see FORBID.
- illegal  output  WIDTH  registered per-cell pulse: S=R=1 was sampled last cycle.
- err_sticky  output  1  set on any illegal sample; held until cleared.
- illegal_cnt  output  CNT_W  number of cycles with at least one illegal sample.

Behaviour:
- Reset (reset=0, asynchronous): every cell goes to Q0 (q=0, qb=1). illegal=0, err_sticky=0, illegal_cnt=0. Reset has priority over everything, including mid-FORBID. Release is synchronous to the next clk edge.
- Each cell is a 3-state FSM, registered, with state changes on the clk edge:
  - Q0 drives q=0, qb=1.
  - Q1 drives q=1, qb=0.
  - FORBID drives q=0, qb=0 (NOR-latch behaviour).
- Transitions when en=1:
  - s=0, r=0: Q0 and Q1 hold. FORBID moves to Q0 if RESOLVE=0, or to Q1 if RESOLVE=1.
  - s=1, r=0: go to Q1 from any state.
  - s=0, r=1: go to Q0 from any state.
  - s=1, r=1: go to FORBID from any state. FORBID stays in FORBID while s=r=1.
- en=0: all states hold. No illegal pulses are generated and no counting occurs.
- Latency: q/qb change one cycle after sampling s/r. They are registered outputs, with no combinational path from s/r.
- illegal[i] is 1 for exactly the cycle after en=1 and s[i]=r[i]=1 were sampled. Consecutive illegal samples give a continuous high.
- err_sticky: set in the cycle after any illegal sample. Cleared by err_clr=1 in the cycle after sampling. If err_clr and a new illegal sample coincide, set wins.
- illegal_cnt: increments by 1 per cycle in which any bit is illegal, regardless of how many bits are illegal. Saturates at 2^CNT_W-1 with no wrap. err_clr zeroes it; with a simultaneous illegal sample the result is 1.
- Cells are fully independent: mixed legal and illegal bits in one cycle are each handled per their own inputs.

Optional Feature:
- Macro: D_TO_SR_ILLEGAL_CNT_EN.
- Defined: illegal_cnt is implemented as specified.
- Undefined: the counter logic is removed and illegal_cnt is tied to 0. The port remains so the interface is stable. illegal and err_sticky are unaffected.

Decomposition:
- Shared package (sr_pkg): state enum {ST_Q0=2'b00, ST_Q1=2'b01, ST_FORBID=2'b10} and RESOLVE constants RES_Q0=0, RES_Q1=1.
- Sub-module sr_cell: one FSM with its q/qb decode and illegal flag, instantiated WIDTH times via generate.
- Top level contains only the OR-reduce of illegal, err_sticky, and the counter.

Test Plan:
1. Reset/hold: hold reset=0 for 3 cycles, then release with en=1, s=0, r=0 → q=4'b0000, qb=4'b1111, illegal=0, illegal_cnt=0.
2. Set/reset: s=4'b0101, r=4'b1010 for 1 cycle → next cycle q=4'b0101, qb=4'b1010. Then en=0 with s=4'b1111, r=4'b0000 → outputs unchanged.
3. Forbidden entry/exit, RESOLVE=0 and RESOLVE=1 builds: s=r=4'b0001 for 2 cycles → q[0]=0, qb[0]=0, illegal[0] high for 2 cycles, illegal_cnt=2. Then s=r=0 → q[0]=RESOLVE, qb[0]=~RESOLVE.
4. Counter semantics: s=r=4'b1111 for 1 cycle → illegal_cnt=1, not 4. Drive with CNT_W=3 for 10 illegal cycles → illegal_cnt=7.
5. Clear collision: err_clr=1 in the same cycle as an illegal sample → err_sticky stays 1 and illegal_cnt=1. err_clr alone → err_sticky=0 and illegal_cnt=0. Without D_TO_SR_ILLEGAL_CNT_EN, illegal_cnt stays 0 throughout.
6. Reset mid-FORBID: a cell in FORBID, then reset pulsed low between clock edges → immediately q=0, qb=1, err_sticky=0.
